nnrv_id: RTL
============

# nnrv_id

Instruction-decode stage of the nnrv RV64I pipeline, directly downstream of the fetch stage. Each cycle it decodes the registered instruction/PC from fetch and reads the register file. It resolves branches and jumps, signalling fetch with a redirect. It detects RAW hazards against EX/MEM, asserting a fetch stall and issuing a bubble, and registers decoded operands and control into the EX pipeline register.

## Interface
- XLEN, 64, datapath/PC width
- INSTR_WIDTH, 32, instruction width
- REG_ADDR_WIDTH, 5, register index width

- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_if_instr  in  INSTR_WIDTH  instruction from fetch
- i_if_cur_pc  in  XLEN  PC of i_if_instr
- o_if_jmp_stall  out  1  redirect fetch (combinational)
- o_if_jmp_pc  out  XLEN  redirect target (combinational)
- o_if_hazard_stall  out  1  fetch must re-present same instruction (combinational)
- o_rf_rs1_addr, o_rf_rs2_addr  out  REG_ADDR_WIDTH  regfile read addresses (combinational)
- i_rf_rs1_data, i_rf_rs2_data  in  XLEN  regfile read data, same cycle, write-first
- i_ex_rd_addr / i_ex_rd_wen  in  REG_ADDR_WIDTH / 1  destination held in EX
- i_mem_rd_addr / i_mem_rd_wen  in  REG_ADDR_WIDTH / 1  destination held in MEM
- o_ex_valid  out  1  EX register holds a real instruction
- o_ex_pc  out  XLEN  instruction PC
- o_ex_op_a, o_ex_op_b  out  XLEN  final ALU operands
- o_ex_rs2_data  out  XLEN  store data
- o_ex_alu_op  out  4  {funct7[5] qualifier, funct3}; 0000 = ADD
- o_ex_word  out  1  32-bit op (OP-32/OP-IMM-32), result sign-extended in EX
- o_ex_rd_addr / o_ex_rd_wen  out  REG_ADDR_WIDTH / 1  destination
- o_ex_mem_rd / o_ex_mem_wr  out  1 / 1  load / store
- o_ex_mem_size  out  2  funct3[1:0]
- o_ex_mem_unsigned  out  1  funct3[2]
- o_illegal  out  1  sticky illegal-instruction flag
- o_illegal_pc  out  XLEN  PC of first illegal instruction

## Operation
- Decode: combinational from i_if_instr; rs1 = instr[19:15], rs2 = instr[24:20]; immediates I/S/B/U/J are sign-extended to XLEN.
- Operands per opcode:
  - LUI: a=0, b=immU
  - AUIPC: a=pc, b=immU
  - JAL/JALR: a=pc, b=4, alu ADD (link)
  - LOAD/STORE: a=rs1, b=immI/immS, ADD
  - OP/OP-32: a=rs1, b=rs2
  - OP-IMM/OP-IMM-32: a=rs1, b=immI; funct7[5] qualifier used only for funct3=101
  - BRANCH: a=rs1, b=rs2, rd_wen=0
  - FENCE/SYSTEM: valid no-op, rd_wen=0
- rd_wen is forced 0 when rd=x0.
- Hazard: for each source actually used by the opcode with index ≠ 0, hazard = (i_ex_rd_wen && i_ex_rd_addr==rs) || (i_mem_rd_wen && i_mem_rd_addr==rs). There is no forwarding; WB-stage writes are covered by the write-first regfile.
- Jumps:
  - JAL target = pc+immJ.
  - JALR target = (rs1+immI) & ~1.
  - Branch target = pc+immB. Taken for BEQ/BNE/BLT/BGE (signed) and BLTU/BGEU, on full-XLEN rs1/rs2.
  - o_if_jmp_stall = valid decode && (JAL || JALR || taken branch) && !hazard && target[1:0]==0.
- Target[1:0] ≠ 0: treated as illegal; no redirect, bubble issued.
- Priority: hazard > jump. A JALR/branch with a hazard raises only o_if_hazard_stall. JAL never hazards.
- Illegal: unknown opcode (excluding all-zero word) or misaligned target.
  - Issues a bubble.
  - If o_illegal=0: sets o_illegal=1 and o_illegal_pc=pc.
  - Subsequent illegals do not update o_illegal_pc.
  - Cleared only by reset.
- All-zero instruction (fetch reset value) is a silent bubble.

## Timing
- Reset (i_rst sampled high at posedge): every registered output is 0 (o_ex_valid, all o_ex_*, o_illegal, o_illegal_pc). While i_rst is high, o_if_jmp_stall and o_if_hazard_stall are forced to 0.
- Latency: decode at cycle N produces EX register contents visible from cycle N+1.
- Redirect: o_if_jmp_stall high for exactly the cycle the jump sits in decode. Fetch captures the target instruction at that same edge, so no flush is needed. The jump itself issues to EX with o_ex_valid=1 (link write).
- Hazard stall: bubble loaded at the edge (o_ex_valid=0, rd_wen=0, mem_rd=0, mem_wr=0; other fields don't-care). Fetch re-presents the instruction next cycle. Stall lasts at most 2 cycles (EX then MEM drain).
- EX has no backpressure into this block.
- Reset mid-stall: next cycle all outputs 0; stall state is not retained.

## Test plan
- Reset/ADDI: i_rst high 2 cycles with instr 0x00500093, pc 0 → all outputs 0. After release → next cycle o_ex_valid=1, op_a=0, op_b=5, rd_addr=1, rd_wen=1, alu_op=0.
- RAW stall: add x3,x1,x2 (0x002081B3) with i_ex_rd_addr=1/wen=1 → o_if_hazard_stall=1, next o_ex_valid=0. Then only i_mem_rd_addr=2/wen=1 → still stall. Both clear → issues with op_a=rs1, op_b=rs2.
- Branch: beq x1,x2,+16 (0x00208863) at pc 0x100, rs1=rs2=7 → o_if_jmp_stall=1, o_if_jmp_pc=0x110, EX rd_wen=0. With rs2=8 → jmp_stall=0.
- JALR: jalr x1,8(x5) (0x008280E7), pc 0x200, rs1=0x2001 → jmp_pc=0x2008; EX op_a=0x200, op_b=4, rd=1. Same with i_ex_rd_addr=5/wen=1 → jmp_stall=0, hazard_stall=1.
- Load sign-extend: lw x4,-4(x2) (0xFFC12203) → op_b=0xFFFFFFFFFFFFFFFC, mem_rd=1, mem_size=2, mem_unsigned=0.
- Illegal: 0xFFFFFFFF at pc 0x40 → next cycle o_illegal=1, o_illegal_pc=0x40, o_ex_valid=0. Second illegal at 0x80 → o_illegal_pc stays 0x40. Instr 0x00000000 → no flag.

Source files
------------

// File: rtl/nnrv_id_if.sv
// Decode-to-execute pipeline register bundle of the nnrv RV64I core.
// The decode stage drives it as master and the execute stage consumes it as slave.
interface nnrv_id_if #(
    parameter int XLEN           = 64,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      o_ex_valid;
    logic [XLEN-1:0]           o_ex_pc;
    logic [XLEN-1:0]           o_ex_op_a;
    logic [XLEN-1:0]           o_ex_op_b;
    logic [XLEN-1:0]           o_ex_rs2_data;
    logic [3:0]                o_ex_alu_op;
    logic                      o_ex_word;
    logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr;
    logic                      o_ex_rd_wen;
    logic                      o_ex_mem_rd;
    logic                      o_ex_mem_wr;
    logic [1:0]                o_ex_mem_size;
    logic                      o_ex_mem_unsigned;

    modport master (
        output o_ex_valid, o_ex_pc, o_ex_op_a, o_ex_op_b, o_ex_rs2_data, o_ex_alu_op,
               o_ex_word, o_ex_rd_addr, o_ex_rd_wen, o_ex_mem_rd, o_ex_mem_wr,
               o_ex_mem_size, o_ex_mem_unsigned
    );
    modport slave (
        input  o_ex_valid, o_ex_pc, o_ex_op_a, o_ex_op_b, o_ex_rs2_data, o_ex_alu_op,
               o_ex_word, o_ex_rd_addr, o_ex_rd_wen, o_ex_mem_rd, o_ex_mem_wr,
               o_ex_mem_size, o_ex_mem_unsigned
    );
endinterface

// File: rtl/nnrv_id.sv
// nnrv RV64I decode stage: decode, regfile read, branch/jump resolution,
// RAW hazard stall against EX/MEM and the ID/EX pipeline register.
module nnrv_id #(
    parameter int XLEN           = 64,
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [INSTR_WIDTH-1:0]    i_if_instr,
    input  logic [XLEN-1:0]           i_if_cur_pc,
    output logic                      o_if_jmp_stall,
    output logic [XLEN-1:0]           o_if_jmp_pc,
    output logic                      o_if_hazard_stall,
    output logic [REG_ADDR_WIDTH-1:0] o_rf_rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] o_rf_rs2_addr,
    input  logic [XLEN-1:0]           i_rf_rs1_data,
    input  logic [XLEN-1:0]           i_rf_rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd_addr,
    input  logic                      i_ex_rd_wen,
    input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd_addr,
    input  logic                      i_mem_rd_wen,
    nnrv_id_if.master                 ex,
    output logic                      o_illegal,
    output logic [XLEN-1:0]           o_illegal_pc
);
    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011,
        OPC_OP_IMM32 = 7'b0011011,
        OPC_OP32     = 7'b0111011,
        OPC_FENCE    = 7'b0001111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic                      valid;
        logic [XLEN-1:0]           pc;
        logic [XLEN-1:0]           op_a;
        logic [XLEN-1:0]           op_b;
        logic [XLEN-1:0]           rs2_data;
        logic [3:0]                alu_op;
        logic                      word;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      rd_wen;
        logic                      mem_rd;
        logic                      mem_wr;
        logic [1:0]                mem_size;
        logic                      mem_unsigned;
    } ex_t;

    ex_t             ex_d, ex_q;
    logic            illegal_d, illegal_q;
    logic [XLEN-1:0] illegal_pc_d, illegal_pc_q;

    opcode_e                   opc;
    logic [2:0]                funct3;
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]           imm_i, imm_s, imm_b, imm_u, imm_j;
    logic                      use_rs1, use_rs2, known, is_jmp, taken;
    logic                      hazard, misaligned, illegal_now, issue;
    logic [XLEN-1:0]           jmp_target;

    always_comb begin
        opc    = opcode_e'(i_if_instr[6:0]);
        funct3 = i_if_instr[14:12];
        rs1    = i_if_instr[19:15];
        rs2    = i_if_instr[24:20];
        rd     = i_if_instr[11:7];
        imm_i  = {{(XLEN-12){i_if_instr[31]}}, i_if_instr[31:20]};
        imm_s  = {{(XLEN-12){i_if_instr[31]}}, i_if_instr[31:25], i_if_instr[11:7]};
        imm_b  = {{(XLEN-12){i_if_instr[31]}}, i_if_instr[7], i_if_instr[30:25],
                  i_if_instr[11:8], 1'b0};
        imm_u  = {{(XLEN-32){i_if_instr[31]}}, i_if_instr[31:12], 12'b0};
        imm_j  = {{(XLEN-20){i_if_instr[31]}}, i_if_instr[19:12], i_if_instr[20],
                  i_if_instr[30:21], 1'b0};

        case (funct3)
            3'b000:  taken = (i_rf_rs1_data == i_rf_rs2_data);
            3'b001:  taken = (i_rf_rs1_data != i_rf_rs2_data);
            3'b100:  taken = ($signed(i_rf_rs1_data) <  $signed(i_rf_rs2_data));
            3'b101:  taken = ($signed(i_rf_rs1_data) >= $signed(i_rf_rs2_data));
            3'b110:  taken = (i_rf_rs1_data <  i_rf_rs2_data);
            3'b111:  taken = (i_rf_rs1_data >= i_rf_rs2_data);
            default: taken = 1'b0;
        endcase

        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        known         = 1'b1;
        is_jmp        = 1'b0;
        jmp_target    = '0;
        ex_d          = '0;
        ex_d.pc       = i_if_cur_pc;
        ex_d.rs2_data = i_rf_rs2_data;
        ex_d.rd_addr  = rd;

        case (opc)
            OPC_LUI: begin
                ex_d.op_b   = imm_u;
                ex_d.rd_wen = 1'b1;
            end
            OPC_AUIPC: begin
                ex_d.op_a   = i_if_cur_pc;
                ex_d.op_b   = imm_u;
                ex_d.rd_wen = 1'b1;
            end
            OPC_JAL: begin
                ex_d.op_a   = i_if_cur_pc;
                ex_d.op_b   = XLEN'(4);
                ex_d.rd_wen = 1'b1;
                is_jmp      = 1'b1;
                jmp_target  = i_if_cur_pc + imm_j;
            end
            OPC_JALR: begin
                ex_d.op_a   = i_if_cur_pc;
                ex_d.op_b   = XLEN'(4);
                ex_d.rd_wen = 1'b1;
                use_rs1     = 1'b1;
                is_jmp      = 1'b1;
                jmp_target  = (i_rf_rs1_data + imm_i) & ~XLEN'(1);
            end
            OPC_BRANCH: begin
                ex_d.op_a  = i_rf_rs1_data;
                ex_d.op_b  = i_rf_rs2_data;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                is_jmp     = taken;
                jmp_target = i_if_cur_pc + imm_b;
            end
            OPC_LOAD, OPC_STORE: begin
                ex_d.op_a         = i_rf_rs1_data;
                ex_d.op_b         = (opc == OPC_LOAD) ? imm_i : imm_s;
                ex_d.rd_wen       = (opc == OPC_LOAD);
                ex_d.mem_rd       = (opc == OPC_LOAD);
                ex_d.mem_wr       = (opc == OPC_STORE);
                ex_d.mem_size     = funct3[1:0];
                ex_d.mem_unsigned = funct3[2];
                use_rs1           = 1'b1;
                use_rs2           = (opc == OPC_STORE);
            end
            OPC_OP, OPC_OP32: begin
                ex_d.op_a   = i_rf_rs1_data;
                ex_d.op_b   = i_rf_rs2_data;
                ex_d.alu_op = {i_if_instr[30], funct3};
                ex_d.word   = (opc == OPC_OP32);
                ex_d.rd_wen = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                ex_d.op_a   = i_rf_rs1_data;
                ex_d.op_b   = imm_i;
                ex_d.alu_op = {i_if_instr[30] & (funct3 == 3'b101), funct3};
                ex_d.word   = (opc == OPC_OP_IMM32);
                ex_d.rd_wen = 1'b1;
                use_rs1     = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: known = 1'b0;
        endcase

        if (rd == '0) ex_d.rd_wen = 1'b0;

        hazard = (use_rs1 && rs1 != '0 &&
                  ((i_ex_rd_wen && i_ex_rd_addr == rs1) || (i_mem_rd_wen && i_mem_rd_addr == rs1))) ||
                 (use_rs2 && rs2 != '0 &&
                  ((i_ex_rd_wen && i_ex_rd_addr == rs2) || (i_mem_rd_wen && i_mem_rd_addr == rs2)));

        // Stale rs1 under a hazard may fake a misaligned JALR target, so hazard masks it.
        misaligned  = is_jmp && !hazard && (jmp_target[1:0] != 2'b00);
        illegal_now = (!known && i_if_instr != '0) || misaligned;
        issue       = known && !hazard && !misaligned;

        ex_d.valid = issue;
        if (!issue) begin
            ex_d.rd_wen = 1'b0;
            ex_d.mem_rd = 1'b0;
            ex_d.mem_wr = 1'b0;
        end

        illegal_d    = illegal_q | illegal_now;
        illegal_pc_d = (illegal_now && !illegal_q) ? i_if_cur_pc : illegal_pc_q;

        o_rf_rs1_addr     = rs1;
        o_rf_rs2_addr     = rs2;
        o_if_jmp_pc       = jmp_target;
        o_if_jmp_stall    = !i_rst && is_jmp && !hazard && !misaligned;
        o_if_hazard_stall = !i_rst && hazard;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q         <= '0;
            illegal_q    <= 1'b0;
            illegal_pc_q <= '0;
        end else begin
            ex_q         <= ex_d;
            illegal_q    <= illegal_d;
            illegal_pc_q <= illegal_pc_d;
        end
    end

    assign ex.o_ex_valid        = ex_q.valid;
    assign ex.o_ex_pc           = ex_q.pc;
    assign ex.o_ex_op_a         = ex_q.op_a;
    assign ex.o_ex_op_b         = ex_q.op_b;
    assign ex.o_ex_rs2_data     = ex_q.rs2_data;
    assign ex.o_ex_alu_op       = ex_q.alu_op;
    assign ex.o_ex_word         = ex_q.word;
    assign ex.o_ex_rd_addr      = ex_q.rd_addr;
    assign ex.o_ex_rd_wen       = ex_q.rd_wen;
    assign ex.o_ex_mem_rd       = ex_q.mem_rd;
    assign ex.o_ex_mem_wr       = ex_q.mem_wr;
    assign ex.o_ex_mem_size     = ex_q.mem_size;
    assign ex.o_ex_mem_unsigned = ex_q.mem_unsigned;
    assign o_illegal            = illegal_q;
    assign o_illegal_pc         = illegal_pc_q;
endmodule
